// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline writeback (MEM_WB) and a long-latency mul/div unit.
// - Pipeline writeback has priority.
// - Mul/div results wait in a small in-order FIFO.
// - A head entry that waits MAX_WAIT cycles, or a full FIFO that is not being
//   served, forces a DRAIN. DRAIN stalls the pipeline while the queued results
//   are written.
//
// Ports:
//   sys_clk        clock, all state on the rising edge
//   sys_start      asynchronous active-low reset
//   wb_valid_i/wb_addr_i/wb_data_i   pipeline writeback request
//   md_valid_i/md_addr_i/md_data_i   mul/div result; md_ready_o accepts it
//   rf_we_o/rf_addr_o/rf_data_o      registered register-file write port
//   pipe_stall_o   freeze IF..MEM_WB while queued results drain
//   md_busy_o      bit r set while any queued entry targets register r
//   md_count_o     FIFO occupancy
//
// Optional feature (macro WB_ARB_PERF_EN):
//   stall_cnt_o    cycles spent with pipe_stall_o=1
//   md_wait_cnt_o  cycles with a queued, unserved result

module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_start,
    input  logic                     wb_valid_i,
    input  logic [4:0]               wb_addr_i,
    input  logic [31:0]              wb_data_i,
    input  logic                     md_valid_i,
    output logic                     md_ready_o,
    input  logic [4:0]               md_addr_i,
    input  logic [31:0]              md_data_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_addr_o,
    output logic [31:0]              rf_data_o,
    output logic                     pipe_stall_o,
    output logic [31:0]              md_busy_o,
    output logic [$clog2(DEPTH):0]   md_count_o
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              md_wait_cnt_o
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned AGEW = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } md_entry_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AGEW-1:0]   age_q, age_d;
    logic [AGEW-1:0]   age_next;
    md_entry_t         fifo_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic [31:0]       rf_data_q, rf_data_d;
    logic              wb_req;
    logic              push;
    logic              pop;
    md_entry_t         head;

    // Handshake and request qualification; x0 never queued nor written.
    assign md_ready_o = sys_start & (count_q != CW'(DEPTH));
    assign push       = md_valid_i & md_ready_o & (md_addr_i != 5'd0);
    assign wb_req     = wb_valid_i & (wb_addr_i != 5'd0) & (state_q != DRAIN);
    assign head       = fifo_q[rd_ptr_q];

    assign rf_we_o      = rf_we_q;
    assign rf_addr_o    = rf_addr_q;
    assign rf_data_o    = rf_data_q;
    assign pipe_stall_o = (state_q == DRAIN);
    assign md_count_o   = count_q;

    // Next-state, port select, aging and FIFO bookkeeping.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        age_d     = age_q;
        age_next  = '0;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_req) begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = wb_addr_i;
                    rf_data_d = wb_data_i;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    rf_we_d   = 1'b1;
                    rf_addr_d = head.addr;
                    rf_data_d = head.data;
                end
                // Age tracks how long the current head has been passed over.
                if ((count_q == '0) || pop)
                    age_next = '0;
                else if (age_q < AGEW'(MAX_WAIT))
                    age_next = age_q + AGEW'(1);
                else
                    age_next = age_q;
                age_d = age_next;
                if ((age_next == AGEW'(MAX_WAIT)) ||
                    ((count_q == CW'(DEPTH)) && !pop))
                    state_d = DRAIN;
            end
            DRAIN: begin
                age_d = '0;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    rf_we_d   = 1'b1;
                    rf_addr_d = head.addr;
                    rf_data_d = head.data;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q + CW'(push) - CW'(pop);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        // Leave DRAIN once the FIFO empties; a same-cycle push keeps it.
        if ((state_q == DRAIN) && (count_d == '0))
            state_d = IDLE;
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            age_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            age_q     <= age_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    // FIFO storage and per-entry valid flags.
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
        end else begin
            if (pop)
                valid_q[rd_ptr_q] <= 1'b0;
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                fifo_q[wr_ptr_q]  <= '{addr: md_addr_i, data: md_data_i};
            end
        end
    end

    // Scoreboard of registers with a pending mul/div result.
    always_comb begin
        md_busy_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i])
                md_busy_o[fifo_q[i].addr] = 1'b1;
    end

`ifdef WB_ARB_PERF_EN
    // Performance counters, free-running and wrapping.
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            stall_cnt_o   <= '0;
            md_wait_cnt_o <= '0;
        end else begin
            if (state_q == DRAIN)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if ((count_q != '0) && !pop)
                md_wait_cnt_o <= md_wait_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_wb_port_arbiter;

    logic        sys_clk;
    logic        sys_start;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        md_valid_i;
    logic        md_ready_o;
    logic [4:0]  md_addr_i;
    logic [31:0] md_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        pipe_stall_o;
    logic [31:0] md_busy_o;
    logic [1:0]  md_count_o;
`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] md_wait_cnt_o;
`endif

    int n_total = 0;
    int n_bad   = 0;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
        .sys_clk      (sys_clk),
        .sys_start    (sys_start),
        .wb_valid_i   (wb_valid_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .md_valid_i   (md_valid_i),
        .md_ready_o   (md_ready_o),
        .md_addr_i    (md_addr_i),
        .md_data_i    (md_data_i),
        .rf_we_o      (rf_we_o),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .pipe_stall_o (pipe_stall_o),
        .md_busy_o    (md_busy_o),
        .md_count_o   (md_count_o)
`ifdef WB_ARB_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .md_wait_cnt_o(md_wait_cnt_o)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_start  = 1'b0;
        wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        md_valid_i = 1'b0; md_addr_i = '0; md_data_i = '0;
        #12;
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_busy_o, md_count_o, md_ready_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h stall=%b busy=%h cnt=%0d rdy=%b, want all 0",
                     rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_busy_o, md_count_o, md_ready_o);
        end
        #10 sys_start = 1'b1;
        step();
        n_total++;
        if (md_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: got %b want 1", md_ready_o);
        end
    endtask

    task automatic test_pipeline();
        logic [4:0]  va [3];
        logic [31:0] vd [3];
        va[0] = 5'd5;  vd[0] = 32'h0000_1234;
        va[1] = 5'd31; vd[1] = 32'hDEAD_BEEF;
        va[2] = 5'd1;  vd[2] = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            wb_valid_i = 1'b1; wb_addr_i = va[k]; wb_data_i = vd[k];
            step();
            n_total++;
            if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, va[k], vd[k]}) begin
                n_bad++;
                $display("FAIL pipe_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         k, rf_we_o, rf_addr_o, rf_data_o, va[k], vd[k]);
            end
        end
        wb_valid_i = 1'b0;
        step();
        n_total++;
        if (rf_we_o !== 1'b0) begin
            n_bad++; $display("FAIL pipe_we_pulse: got %b want 0", rf_we_o);
        end
    endtask

    task automatic test_x0_filter();
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
        step();
        n_total++;
        if (rf_we_o !== 1'b0) begin
            n_bad++; $display("FAIL x0_pipe_we: got %b want 0", rf_we_o);
        end
        wb_valid_i = 1'b0;
        md_valid_i = 1'b1; md_addr_i = 5'd0; md_data_i = 32'h5A5A_5A5A;
        step();
        md_valid_i = 1'b0;
        n_total++;
        if ({md_count_o, rf_we_o, md_busy_o} !== {2'd0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL x0_md_push: got cnt=%0d we=%b busy=%h want cnt=0 we=0 busy=0",
                     md_count_o, rf_we_o, md_busy_o);
        end
    endtask

    task automatic test_idle_gap();
        md_valid_i = 1'b1; md_addr_i = 5'd7; md_data_i = 32'h0000_00AA;
        step();
        md_valid_i = 1'b0;
        n_total++;
        if ({md_busy_o, md_count_o, rf_we_o} !== {32'h0000_0080, 2'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_push: got busy=%h cnt=%0d we=%b want busy=00000080 cnt=1 we=0",
                     md_busy_o, md_count_o, rf_we_o);
        end
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, md_busy_o, md_count_o} !==
            {1'b1, 5'd7, 32'h0000_00AA, 32'h0, 2'd0}) begin
            n_bad++;
            $display("FAIL idle_pop: got we=%b addr=%0d data=%h busy=%h cnt=%0d want we=1 addr=7 data=aa busy=0 cnt=0",
                     rf_we_o, rf_addr_o, rf_data_o, md_busy_o, md_count_o);
        end
    endtask

    task automatic test_aging();
        wb_valid_i = 1'b1; wb_addr_i = 5'd10; wb_data_i = 32'h0000_5555;
        md_valid_i = 1'b1; md_addr_i = 5'd9;  md_data_i = 32'h0000_0099;
        step();
        md_valid_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_total++;
            if ({pipe_stall_o, rf_we_o, rf_addr_o, md_count_o} !== {1'b0, 1'b1, 5'd10, 2'd1}) begin
                n_bad++;
                $display("FAIL aging_wait[%0d]: got stall=%b we=%b addr=%0d cnt=%0d want stall=0 we=1 addr=10 cnt=1",
                         k, pipe_stall_o, rf_we_o, rf_addr_o, md_count_o);
            end
        end
        step();
        n_total++;
        if (pipe_stall_o !== 1'b1) begin
            n_bad++; $display("FAIL aging_stall: got %b want 1", pipe_stall_o);
        end
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o} !==
            {1'b1, 5'd9, 32'h0000_0099, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL aging_drain: got we=%b addr=%0d data=%h stall=%b cnt=%0d want we=1 addr=9 data=99 stall=0 cnt=0",
                     rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o);
        end
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, 5'd10, 32'h0000_5555}) begin
            n_bad++;
            $display("FAIL aging_held_wb: got we=%b addr=%0d data=%h want we=1 addr=10 data=5555",
                     rf_we_o, rf_addr_o, rf_data_o);
        end
        wb_valid_i = 1'b0;
        step();
    endtask

    // Fill both entries while the pipeline keeps the port busy; ends in DRAIN with count=2.
    task automatic fill_fifo();
        wb_valid_i = 1'b1; wb_addr_i = 5'd10; wb_data_i = 32'h0000_A0A0;
        md_valid_i = 1'b1; md_addr_i = 5'd3;  md_data_i = 32'h0000_0033;
        step();
        md_addr_i = 5'd4; md_data_i = 32'h0000_0044;
        step();
        md_valid_i = 1'b0;
        n_total++;
        if ({md_ready_o, md_count_o, md_busy_o, pipe_stall_o} !== {1'b0, 2'd2, 32'h0000_0018, 1'b0}) begin
            n_bad++;
            $display("FAIL full_state: got rdy=%b cnt=%0d busy=%h stall=%b want rdy=0 cnt=2 busy=00000018 stall=0",
                     md_ready_o, md_count_o, md_busy_o, pipe_stall_o);
        end
        step();
        n_total++;
        if ({pipe_stall_o, md_count_o} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL full_drain_enter: got stall=%b cnt=%0d want stall=1 cnt=2", pipe_stall_o, md_count_o);
        end
    endtask

    task automatic test_full();
        fill_fifo();
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o, md_ready_o} !==
            {1'b1, 5'd3, 32'h0000_0033, 1'b1, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL full_first: got we=%b addr=%0d data=%h stall=%b cnt=%0d rdy=%b want 1/3/33/1/1/1",
                     rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o, md_ready_o);
        end
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o, md_busy_o} !==
            {1'b1, 5'd4, 32'h0000_0044, 1'b0, 2'd0, 32'h0}) begin
            n_bad++;
            $display("FAIL full_second: got we=%b addr=%0d data=%h stall=%b cnt=%0d busy=%h want 1/4/44/0/0/0",
                     rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_count_o, md_busy_o);
        end
        step();
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, 5'd10, 32'h0000_A0A0}) begin
            n_bad++;
            $display("FAIL full_resume_wb: got we=%b addr=%0d data=%h want we=1 addr=10 data=a0a0",
                     rf_we_o, rf_addr_o, rf_data_o);
        end
        wb_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_in_drain();
        fill_fifo();
        wb_valid_i = 1'b0;
        #2 sys_start = 1'b0;
        #1;
        n_total++;
        if ({rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_busy_o, md_count_o, md_ready_o} !== '0) begin
            n_bad++;
            $display("FAIL drain_reset: we=%b addr=%0d data=%h stall=%b busy=%h cnt=%0d rdy=%b, want all 0",
                     rf_we_o, rf_addr_o, rf_data_o, pipe_stall_o, md_busy_o, md_count_o, md_ready_o);
        end
        #2 sys_start = 1'b1;
        step();
        n_total++;
        if ({md_ready_o, md_count_o, rf_we_o, pipe_stall_o} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_reset_release: got rdy=%b cnt=%0d we=%b stall=%b want rdy=1 cnt=0 we=0 stall=0",
                     md_ready_o, md_count_o, rf_we_o, pipe_stall_o);
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_x0_filter();
        test_idle_gap();
        test_aging();
        test_full();
        test_reset_in_drain();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
